// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase sequencer. Latched crosswalk requests are served in an
// all-red WALK phase. All phase timing counts one-clk tick_en strobes.
module traffic_phase_scheduler #(
    parameter int CNT_W     = 8,
    parameter int T_GREEN   = 10,
    parameter int MIN_GREEN = 4,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 1,
    parameter int T_WALK    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic [3:0] ped_req,
    output logic       NS_G,
    output logic       NS_Y,
    output logic       NS_R,
    output logic       EW_G,
    output logic       EW_Y,
    output logic       EW_R,
    output logic       WALK,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        WALK_A    = 3'd6,
        WALK_B    = 3'd7
    } state_e;

    typedef struct packed {
        logic ns_g;
        logic ns_y;
        logic ns_r;
        logic ew_g;
        logic ew_y;
        logic ew_r;
        logic walk;
    } lamps_t;

    // Last elapsed value of each state: a state ends on the tick where elapsed hits it.
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
    localparam lamps_t LAMPS_ALLRED = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0] dur_last;
    logic             pending_q, pending_d;
    logic [3:0]       sync1_q, sync2_q, prev_q;
    lamps_t           lamps_q, lamps_d;
    logic             ped_ack_q, ped_ack_d;
    logic [2:0]       phase_q;
    logic             any_edge, pend_now, is_green, leave;

    // NOTE: every flop uses <= so all registers sample pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= ped_req;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        dur_last = GREEN_LAST;
        case (state_q)
            NS_GREEN, EW_GREEN:   dur_last = GREEN_LAST;
            NS_YELLOW, EW_YELLOW: dur_last = YELLOW_LAST;
            ALLRED_A, ALLRED_B:   dur_last = ALLRED_LAST;
            default:              dur_last = WALK_LAST;
        endcase
    end

    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    always_comb begin
        any_edge = |(sync2_q & ~prev_q);
        pend_now = pending_q | any_edge;
        is_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);
        leave    = tick_en &&
                   ((elapsed_q == dur_last) ||
                    (is_green && pend_now && (elapsed_q >= MIN_LAST)));

        state_d = state_q;
        if (leave) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALLRED_A;
                ALLRED_A:  state_d = pend_now ? WALK_A : EW_GREEN;
                WALK_A:    state_d = EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALLRED_B;
                ALLRED_B:  state_d = pend_now ? WALK_B : NS_GREEN;
                default:   state_d = NS_GREEN;
            endcase
        end

        // Entering WALK serves the request; an edge arriving on that very cycle re-arms it.
        ped_ack_d = leave && ((state_d == WALK_A) || (state_d == WALK_B));
        pending_d = ped_ack_d ? any_edge : pend_now;

        elapsed_d = elapsed_q;
        if (leave) begin
            elapsed_d = '0;
        end else if (tick_en && (elapsed_q != '1)) begin
            elapsed_d = elapsed_q + 1'b1;
        end
    end

    always_comb begin
        lamps_d = LAMPS_ALLRED;
        case (state_d)
            NS_GREEN: begin
                lamps_d.ns_g = 1'b1;
                lamps_d.ns_r = 1'b0;
            end
            NS_YELLOW: begin
                lamps_d.ns_y = 1'b1;
                lamps_d.ns_r = 1'b0;
            end
            EW_GREEN: begin
                lamps_d.ew_g = 1'b1;
                lamps_d.ew_r = 1'b0;
            end
            EW_YELLOW: begin
                lamps_d.ew_y = 1'b1;
                lamps_d.ew_r = 1'b0;
            end
            WALK_A, WALK_B: lamps_d.walk = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ALLRED_B;
            elapsed_q <= '0;
            pending_q <= 1'b0;
            lamps_q   <= LAMPS_ALLRED;
            ped_ack_q <= 1'b0;
            phase_q   <= ALLRED_B;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            pending_q <= pending_d;
            lamps_q   <= lamps_d;
            ped_ack_q <= ped_ack_d;
            phase_q   <= state_d;
        end
    end

    assign NS_G    = lamps_q.ns_g;
    assign NS_Y    = lamps_q.ns_y;
    assign NS_R    = lamps_q.ns_r;
    assign EW_G    = lamps_q.ew_g;
    assign EW_Y    = lamps_q.ew_y;
    assign EW_R    = lamps_q.ew_r;
    assign WALK    = lamps_q.walk;
    assign ped_ack = ped_ack_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random stimulus, all checked
// against a countdown-based behavioural model of the phase rules.
module tb_traffic_phase_scheduler;

    localparam int T_GREEN   = 5;
    localparam int MIN_GREEN = 2;
    localparam int T_YELLOW  = 2;
    localparam int T_ALLRED  = 1;
    localparam int T_WALK    = 3;
    localparam logic [10:0] RESET_VEC = {3'd5, 7'b0010010, 1'b0};

    logic       clk, rst, tick_en;
    logic [3:0] ped_req;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack;
    logic [2:0] phase;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: phase number, ticks remaining in it, pending flag, button history.
    int         m_phase, m_rem;
    bit         m_pend, m_ack;
    logic [3:0] m_s1, m_s2, m_s3;

    traffic_phase_scheduler #(
        .CNT_W(8), .T_GREEN(T_GREEN), .MIN_GREEN(MIN_GREEN),
        .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_WALK(T_WALK)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .ped_req(ped_req),
        .NS_G(ns_g), .NS_Y(ns_y), .NS_R(ns_r),
        .EW_G(ew_g), .EW_Y(ew_y), .EW_R(ew_r),
        .WALK(walk), .ped_ack(ped_ack), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst) begin
            n_vec++;
            if (!$onehot({ns_g, ns_y, ns_r}) || !$onehot({ew_g, ew_y, ew_r}) || (!ns_r && !ew_r)) begin
                n_err++;
                $display("FAIL lamp_invariant: ns=%b ew=%b, required one lamp per direction and one direction red",
                         {ns_g, ns_y, ns_r}, {ew_g, ew_y, ew_r});
            end
        end
    end

    function automatic int dur(input int p);
        case (p)
            0, 3:    return T_GREEN;
            1, 4:    return T_YELLOW;
            2, 5:    return T_ALLRED;
            default: return T_WALK;
        endcase
    endfunction

    function automatic logic [10:0] lamps_of(input int p, input bit ack);
        logic ng, ny, eg, ey;
        ng = (p == 0);
        ny = (p == 1);
        eg = (p == 3);
        ey = (p == 4);
        return {3'(p), ng, ny, !(ng || ny), eg, ey, !(eg || ey), (p >= 6), ack};
    endfunction

    function automatic logic [10:0] exp_vec();
        return lamps_of(m_phase, m_ack);
    endfunction

    function automatic logic [10:0] dut_vec();
        return {phase, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack};
    endfunction

    task automatic model_reset();
        m_phase = 5;
        m_rem   = T_ALLRED;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
        m_s1    = '0;
        m_s2    = '0;
        m_s3    = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_clock(input logic [3:0] pd, input logic tk);
        bit any, pnow, done;
        int nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        any   = |(m_s2 & ~m_s3);
        pnow  = m_pend || any;
        done  = 1'b0;
        m_ack = 1'b0;
        if (tk) begin
            if (m_rem == 1) done = 1'b1;
            else if ((m_phase == 0 || m_phase == 3) && pnow && (T_GREEN - m_rem) >= MIN_GREEN - 1) done = 1'b1;
            if (!done) m_rem--;
        end
        if (done) begin
            case (m_phase)
                0:       nxt = 1;
                1:       nxt = 2;
                2:       nxt = pnow ? 6 : 3;
                3:       nxt = 4;
                4:       nxt = 5;
                5:       nxt = pnow ? 7 : 0;
                6:       nxt = 3;
                default: nxt = 0;
            endcase
            m_phase = nxt;
            m_rem   = dur(nxt);
            m_ack   = (nxt >= 6);
        end
        m_pend = m_ack ? any : pnow;
        m_s3 = m_s2;
        m_s2 = m_s1;
        m_s1 = pd;
    endtask

    task automatic step(input logic [3:0] pd, input logic tk);
        ped_req = pd;
        tick_en = tk;
        @(posedge clk);
        model_clock(pd, tk);
        cyc++;
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ped_req = '0;
        tick_en = 1'b0;
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (dut_vec() !== RESET_VEC) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b", dut_vec(), RESET_VEC);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'hF, 1'b1);
            n_vec++;
            if (dut_vec() !== RESET_VEC) begin
                n_err++;
                $display("FAIL reset_hold: got %b required %b", dut_vec(), RESET_VEC);
            end
        end
    endtask

    task automatic test_no_buttons();
        int ns_cnt, ew_cnt, walk_cnt;
        ns_cnt = 0; ew_cnt = 0; walk_cnt = 0;
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            step(4'h0, logic'(cyc % 4 == 0));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL no_buttons cyc %0d: got %b required %b", cyc, dut_vec(), exp_vec());
            end
            if (phase == 3'd0) ns_cnt++;
            if (phase == 3'd3) ew_cnt++;
            if (walk) walk_cnt++;
        end
        n_vec++;
        if (ns_cnt != 40 || ew_cnt != 40 || walk_cnt != 0) begin
            n_err++;
            $display("FAIL no_buttons_durations: ns_green=%0d ew_green=%0d walk=%0d clk, required 40 40 0",
                     ns_cnt, ew_cnt, walk_cnt);
        end
    endtask

    task automatic test_early_green(input int e, input int b);
        int gticks, exp_ticks, acks, walk_cyc;
        bit pulsed, measured, done;
        logic [2:0] pre;
        logic [3:0] pd;
        logic tk;
        exp_ticks = (e + 1 < MIN_GREEN) ? MIN_GREEN : e + 1;
        if (exp_ticks > T_GREEN) exp_ticks = T_GREEN;
        gticks = 0; acks = 0; walk_cyc = 0;
        pulsed = 1'b0; measured = 1'b0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            pd = '0;
            tk = logic'(cyc % 4 == 0);
            if (!pulsed && cyc % 4 == 1 && m_phase == 0 && (T_GREEN - m_rem) == e) begin
                pd[b] = 1'b1;
                pulsed = 1'b1;
            end
            pre = phase;
            step(pd, tk);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL early_green_e%0d cyc %0d: got %b required %b", e, cyc, dut_vec(), exp_vec());
            end
            if (pre != 3'd0 && phase == 3'd0) gticks = 0;
            else if (tk && pre == 3'd0) gticks++;
            if (pulsed && !measured && pre == 3'd0 && phase != 3'd0) begin
                measured = 1'b1;
                n_vec++;
                if (gticks != exp_ticks) begin
                    n_err++;
                    $display("FAIL green_length_e%0d: got %0d ticks required %0d", e, gticks, exp_ticks);
                end
            end
            if (pulsed) begin
                if (ped_ack) acks++;
                if (walk) walk_cyc++;
                if (acks > 0 && phase == 3'd3) done = 1'b1;
            end
        end
        n_vec++;
        if (!done || acks != 1 || walk_cyc != T_WALK * 4) begin
            n_err++;
            $display("FAIL walk_service_e%0d: reached_ew=%0d acks=%0d walk_clk=%0d, required 1 1 %0d",
                     e, done, acks, walk_cyc, T_WALK * 4);
        end
    endtask

    task automatic test_walk_entry_edge();
        int acks;
        logic [2:0] pre;
        logic [3:0] pd;
        acks = 0;
        for (int i = 0; i < 320; i++) begin
            pd = '0;
            pd[1] = (i == 1);
            pd[0] = (i < 160) && (cyc % 4 == 2) && (m_phase == 2 || m_phase == 5) && m_pend && (m_rem == 1);
            pd[3] = (i >= 160) && (m_phase >= 6);
            pre = phase;
            step(pd, logic'(cyc % 4 == 0));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL walk_entry_edge cyc %0d: got %b required %b", cyc, dut_vec(), exp_vec());
            end
            if (acks > 0 && (pre == 3'd2 || pre == 3'd5) && pre != phase) begin
                n_vec++;
                if (phase == 3'd0 || phase == 3'd3) begin
                    n_err++;
                    $display("FAIL walk_rearm cyc %0d: all-red went to phase %0d, required walk", cyc, phase);
                end
            end
            if (ped_ack) acks++;
        end
        n_vec++;
        if (acks < 3) begin
            n_err++;
            $display("FAIL walk_rearm_count: got %0d walks required at least 3", acks);
        end
    endtask

    task automatic test_async_reset();
        int acks;
        bit found;
        for (int pass = 0; pass < 2; pass++) begin
            found = 1'b0;
            for (int i = 0; i < 300 && !found; i++) begin
                step((pass == 1 && i == 0) ? 4'h2 : 4'h0, logic'(cyc % 4 == 0));
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL pre_reset_p%0d cyc %0d: got %b required %b", pass, cyc, dut_vec(), exp_vec());
                end
                found = (pass == 0) ? (m_phase == 4 && cyc % 4 == 2) : (m_phase >= 6 && m_rem == 2);
            end
            n_vec++;
            if (!found) begin
                n_err++;
                $display("FAIL reset_target_p%0d: target phase not reached, got phase %0d", pass, m_phase);
            end
            pulse_reset();
            n_vec++;
            if (dut_vec() !== RESET_VEC) begin
                n_err++;
                $display("FAIL async_reset_p%0d: got %b required %b", pass, dut_vec(), RESET_VEC);
            end
            step(4'h0, 1'b1);
            step(4'h0, 1'b1);
            rst = 1'b1;
            acks = 0;
            for (int i = 0; i < 48; i++) begin
                step(4'h0, logic'(cyc % 4 == 0));
                n_vec++;
                if (dut_vec() !== exp_vec()) begin
                    n_err++;
                    $display("FAIL post_reset_p%0d cyc %0d: got %b required %b", pass, cyc, dut_vec(), exp_vec());
                end
                if (ped_ack) acks++;
            end
            n_vec++;
            if (acks != 0) begin
                n_err++;
                $display("FAIL reset_clears_pending_p%0d: got %0d walks required 0", pass, acks);
            end
        end
    endtask

    task automatic test_held_inputs();
        int acks;
        acks = 0;
        pulse_reset();
        step(4'h0, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(4'hF, 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL held_inputs cyc %0d: got %b required %b", cyc, dut_vec(), exp_vec());
            end
            if (ped_ack) acks++;
        end
        n_vec++;
        if (acks != 1) begin
            n_err++;
            $display("FAIL held_single_request: got %0d walks required 1", acks);
        end
    endtask

    task automatic test_random();
        logic [3:0] cur;
        cur = 4'hF;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                n_vec++;
                if (dut_vec() !== RESET_VEC) begin
                    n_err++;
                    $display("FAIL random_reset cyc %0d: got %b required %b", cyc, dut_vec(), RESET_VEC);
                end
                step(cur, 1'b1);
                rst = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) cur = cur ^ 4'($urandom_range(0, 15));
            step(cur, logic'($urandom_range(0, 2) == 0));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b required %b", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_buttons();
        test_early_green(0, 0);
        test_early_green(3, 2);
        test_early_green(4, 2);
        test_walk_entry_edge();
        test_async_reset();
        test_held_inputs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
